// File: rtl/conv_pkg.sv
// Shared conv-layer package: conv2 row geometry, derived bus widths,
// the row-streamer FSM state type and a small last-row helper.
package conv_pkg;

    localparam int PIX_W         = 8;
    localparam int CONV2_ROW_PIX = 36;
    localparam int CONV2_ROWS    = 32;

    localparam int ROW_W   = PIX_W * CONV2_ROW_PIX;
    localparam int FRAME_W = ROW_W * CONV2_ROWS;
    localparam int IDX_W   = $clog2(CONV2_ROWS);

    localparam logic [IDX_W-1:0] CONV2_LAST_IDX = IDX_W'(CONV2_ROWS - 1);
    localparam logic [IDX_W-1:0] CONV2_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] CONV2_IDX_ZERO = IDX_W'(0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } conv2_state_e;

    // True when the row index addresses the final row of a frame.
    function automatic logic conv2_is_last(input logic [IDX_W-1:0] idx);
        return (idx == CONV2_LAST_IDX);
    endfunction

endpackage

// File: rtl/conv2_row_sel.sv
// Registered ROWS:1 row multiplexer for the conv2 row streamer.
// Selects one ROW_W slice of the frame word into an output register,
// or clears the register when no row is being presented.
module conv2_row_sel
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [IDX_W-1:0]   sel_i,
    input  logic               clr_i,
    output logic [ROW_W-1:0]   row_o
);

    // Capture the selected row (or zero while idle) on every clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_o <= {ROW_W{1'b0}};
        end else if (clr_i) begin
            row_o <= {ROW_W{1'b0}};
        end else begin
            row_o <= frame_i[int'(sel_i) * ROW_W +: ROW_W];
        end
    end

endmodule

// File: rtl/conv2_row_streamer.sv
// conv2_row_streamer: captures a full conv2 result frame from a one-cycle
// strobe and replays it row by row over a valid/ready stream.
// All stream outputs are registered; the row register is loaded from the
// next-cycle buffer/counter values so row 0 appears one cycle after the strobe.
// Optional feature macro: CONV2_ROW_OVF_EN adds a sticky ovf_o flag that
// records frames dropped because a frame was still being streamed.
module conv2_row_streamer
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               frame_valid_i,
    output logic [ROW_W-1:0]   row_o,
    output logic               row_valid_o,
    input  logic               row_ready_i,
    output logic [IDX_W-1:0]   row_idx_o,
    output logic               row_last_o,
    output logic               busy_o
`ifdef CONV2_ROW_OVF_EN
    ,
    output logic               ovf_o
`endif
);

    conv2_state_e        state_r;
    conv2_state_e        state_next_s;
    logic [IDX_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    cnt_next_s;
    logic [FRAME_W-1:0]  frame_buf_r;
    logic [FRAME_W-1:0]  frame_buf_next_s;

    logic                hs_s;
    logic                last_s;
    logic                accept_s;

    logic                busy_next_s;
    logic [IDX_W-1:0]    idx_next_s;
    logic                last_next_s;

    // State, row counter and frame buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CONV2_IDX_ZERO;
            frame_buf_r <= {FRAME_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            frame_buf_r <= frame_buf_next_s;
        end
    end

    // Next-state logic: accept a frame when idle or exactly as the last row leaves.
    always_comb begin
        hs_s             = (state_r == SEND) && row_ready_i;
        last_s           = conv2_is_last(cnt_r);
        accept_s         = 1'b0;
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        frame_buf_next_s = frame_buf_r;

        case (state_r)
            IDLE: begin
                if (frame_valid_i) begin
                    accept_s     = 1'b1;
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (hs_s && last_s) begin
                    if (frame_valid_i) begin
                        accept_s     = 1'b1;
                        state_next_s = SEND;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if (accept_s) begin
            cnt_next_s       = CONV2_IDX_ZERO;
            frame_buf_next_s = frame_i;
        end else if (hs_s && !last_s) begin
            cnt_next_s       = cnt_r + CONV2_IDX_ONE;
        end else begin
            cnt_next_s       = cnt_r;
        end
    end

    // Output decode for the coming cycle: index/last only meaningful while sending.
    always_comb begin
        busy_next_s = (state_next_s == SEND);
        idx_next_s  = CONV2_IDX_ZERO;
        last_next_s = 1'b0;
        if (busy_next_s) begin
            idx_next_s  = cnt_next_s;
            last_next_s = conv2_is_last(cnt_next_s);
        end else begin
            idx_next_s  = CONV2_IDX_ZERO;
            last_next_s = 1'b0;
        end
    end

    // Registered stream control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            row_idx_o   <= CONV2_IDX_ZERO;
            row_last_o  <= 1'b0;
        end else begin
            row_valid_o <= busy_next_s;
            busy_o      <= busy_next_s;
            row_idx_o   <= idx_next_s;
            row_last_o  <= last_next_s;
        end
    end

    conv2_row_sel u_row_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .frame_i (frame_buf_next_s),
        .sel_i   (idx_next_s),
        .clr_i   (!busy_next_s),
        .row_o   (row_o)
    );

`ifdef CONV2_ROW_OVF_EN
    logic drop_s;
    assign drop_s = frame_valid_i && !accept_s;

    // Sticky overflow: any strobe that could not be accepted sets it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= 1'b0;
        end else begin
            ovf_o <= ovf_o | drop_s;
        end
    end
`endif

endmodule

// File: tb/tb_conv2_row_streamer.sv
// Scoreboard testbench for conv2_row_streamer (directed frames).
// Build with CONV2_ROW_OVF_EN defined to also check the overflow flag.
module tb_conv2_row_streamer;

    localparam int PIX_W   = 8;
    localparam int NPIX    = 36;
    localparam int ROWS    = 32;
    localparam int ROW_W   = PIX_W * NPIX;
    localparam int FRAME_W = ROW_W * ROWS;

    typedef struct {
        logic [ROW_W-1:0] row;
        logic [4:0]       idx;
        logic             last;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [FRAME_W-1:0] frame_i;
    logic               frame_valid_i;
    logic [ROW_W-1:0]   row_o;
    logic               row_valid_o;
    logic               row_ready_i;
    logic [4:0]         row_idx_o;
    logic               row_last_o;
    logic               busy_o;
`ifdef CONV2_ROW_OVF_EN
    logic               ovf_o;
`endif

    int   checks;
    int   failures;
    int   hs_cnt;
    exp_t exp_q[$];

    conv2_row_streamer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_i       (frame_i),
        .frame_valid_i (frame_valid_i),
        .row_o         (row_o),
        .row_valid_o   (row_valid_o),
        .row_ready_i   (row_ready_i),
        .row_idx_o     (row_idx_o),
        .row_last_o    (row_last_o),
        .busy_o        (busy_o)
`ifdef CONV2_ROW_OVF_EN
        ,
        .ovf_o         (ovf_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel p of row r in frame "tag" is (r + tag*p) mod 256; tag 0 gives pixels = r.
    function automatic logic [ROW_W-1:0] mk_row(input int tag, input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int p = 0; p < NPIX; p++) v[p*PIX_W +: PIX_W] = 8'(r + tag * p);
        return v;
    endfunction

    function automatic logic [FRAME_W-1:0] mk_frame(input int tag);
        logic [FRAME_W-1:0] f;
        for (int r = 0; r < ROWS; r++) f[r*ROW_W +: ROW_W] = mk_row(tag, r);
        return f;
    endfunction

    task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle strobe; when the frame will be accepted, queue its 32 rows.
    task automatic send_frame(input int tag, input bit accepted);
        frame_i       = mk_frame(tag);
        frame_valid_i = 1'b1;
        if (accepted) begin
            for (int r = 0; r < ROWS; r++) begin
                exp_t e;
                e.row  = mk_row(tag, r);
                e.idx  = 5'(r);
                e.last = (r == ROWS - 1);
                exp_q.push_back(e);
            end
        end
        cyc();
        frame_valid_i = 1'b0;
    endtask

    // Advance until the presented row index equals target (bounded).
    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while ((row_idx_o != 5'(target) || !row_valid_o) && n < 80) begin
            cyc();
            n++;
        end
        chk("wait_idx_reached", ROW_W'(row_idx_o), ROW_W'(target));
    endtask

    // Count negedges with busy high until the frame drains (bounded).
    task automatic wait_idle(input string nm, input int expect_n);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy_o) break;
            n++;
            if (n > 300) break;
        end
        chk(nm, ROW_W'(n), ROW_W'(expect_n));
    endtask

    // Monitor: scoreboard pops on handshakes, stall stability, valid==busy.
    initial begin
        logic             hold_v;
        logic [ROW_W-1:0] hold_row;
        logic [4:0]       hold_idx;
        logic             hold_last;
        exp_t             e;
        hold_v = 1'b0;
        hold_row = '0;
        hold_idx = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                chk("valid_eq_busy", ROW_W'(row_valid_o), ROW_W'(busy_o));
                if (hold_v && row_valid_o) begin
                    chk("hold_row", row_o, hold_row);
                    chk("hold_idx", ROW_W'(row_idx_o), ROW_W'(hold_idx));
                    chk("hold_last", ROW_W'(row_last_o), ROW_W'(hold_last));
                end
                if (row_valid_o && row_ready_i) begin
                    hs_cnt++;
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_row actual_idx=%0d expected=none", row_idx_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("row_data", row_o, e.row);
                        chk("row_idx", ROW_W'(row_idx_o), ROW_W'(e.idx));
                        chk("row_last", ROW_W'(row_last_o), ROW_W'(e.last));
                    end
                end else if (row_valid_o) begin
                    hold_v    = 1'b1;
                    hold_row  = row_o;
                    hold_idx  = row_idx_o;
                    hold_last = row_last_o;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        int hs0;
        checks        = 0;
        failures      = 0;
        hs_cnt        = 0;
        rst_n         = 1'b0;
        frame_i       = '0;
        frame_valid_i = 1'b0;
        row_ready_i   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_row", row_o, '0);
        chk("rst_valid", ROW_W'(row_valid_o), '0);
        chk("rst_idx", ROW_W'(row_idx_o), '0);
        chk("rst_last", ROW_W'(row_last_o), '0);
        chk("rst_busy", ROW_W'(busy_o), '0);
`ifdef CONV2_ROW_OVF_EN
        chk("rst_ovf", ROW_W'(ovf_o), '0);
`endif
        rst_n = 1'b1;
        cyc();

        // 1: pixels = row index, ready held high
        send_frame(0, 1'b1);
        @(negedge clk);
        chk("t1_latency_valid", ROW_W'(row_valid_o), ROW_W'(1));
        chk("t1_latency_idx", ROW_W'(row_idx_o), '0);
        chk("t1_row0", row_o, mk_row(0, 0));
        wait_idle("t1_drain_cycles", 31);
        chk("t1_idle_valid", ROW_W'(row_valid_o), '0);

        // 2: ready toggles 1010...
        cyc();
        hs0 = hs_cnt;
        send_frame(2, 1'b1);
        for (int i = 0; i < 200; i++) begin
            cyc();
            row_ready_i = ~row_ready_i;
            if (!busy_o) break;
        end
        row_ready_i = 1'b1;
        chk("t2_handshakes", ROW_W'(hs_cnt - hs0), ROW_W'(32));
        chk("t2_idle", ROW_W'(busy_o), '0);

        // 3: back-to-back frame on last-row handshake
        cyc();
        send_frame(1, 1'b1);
        wait_idx(31);
        send_frame(3, 1'b1);
        @(negedge clk);
        chk("t3_no_bubble_valid", ROW_W'(row_valid_o), ROW_W'(1));
        chk("t3_new_idx0", ROW_W'(row_idx_o), '0);
        chk("t3_new_row0", row_o, mk_row(3, 0));
        wait_idle("t3_drain_cycles", 31);

        // 4: frame strobed mid-stream is dropped
        cyc();
`ifdef CONV2_ROW_OVF_EN
        chk("t4_ovf_before", ROW_W'(ovf_o), '0);
`endif
        send_frame(5, 1'b1);
        wait_idx(10);
        send_frame(7, 1'b0);
        chk("t4_after_drop_idx", ROW_W'(row_idx_o), ROW_W'(11));
        chk("t4_after_drop_row", row_o, mk_row(5, 11));
`ifdef CONV2_ROW_OVF_EN
        chk("t4_ovf_set", ROW_W'(ovf_o), ROW_W'(1));
`endif
        wait_idle("t4_drain_cycles", 21);
        chk("t4_queue_empty", ROW_W'(exp_q.size()), '0);

        // 5: reset in the middle of a frame
        cyc();
        send_frame(9, 1'b1);
        wait_idx(5);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t5_rst_row", row_o, '0);
        chk("t5_rst_valid", ROW_W'(row_valid_o), '0);
        chk("t5_rst_idx", ROW_W'(row_idx_o), '0);
        chk("t5_rst_busy", ROW_W'(busy_o), '0);
`ifdef CONV2_ROW_OVF_EN
        chk("t5_rst_ovf", ROW_W'(ovf_o), '0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t5_stays_idle", ROW_W'(busy_o), '0);
        end

        // 6: long stall on row 0, then normal drain
        cyc();
        row_ready_i = 1'b0;
        send_frame(11, 1'b1);
        repeat (100) @(negedge clk);
        chk("t6_stall_busy", ROW_W'(busy_o), ROW_W'(1));
        chk("t6_stall_idx", ROW_W'(row_idx_o), '0);
        chk("t6_stall_row", row_o, mk_row(11, 0));
        cyc();
        row_ready_i = 1'b1;
        wait_idle("t6_drain_cycles", 32);
        chk("t6_queue_empty", ROW_W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
